// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that funnels NREQ requester commands onto one shared APB master.
// Optional watchdog abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int WDATA       = 16,
  parameter int WADDR       = 16,
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   i_PCLK,
  input  logic                   i_PRESETn,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*WADDR-1:0]  i_req_addr,
  input  logic [NREQ-1:0]        i_req_rw,
  input  logic [NREQ*WDATA-1:0]  i_req_wdata,
  input  logic                   i_PSEL,
  input  logic                   i_PENABLE,
  input  logic                   i_PREADY,
  input  logic [WDATA-1:0]       i_PRDATA,
  output logic                   o_TRANSACTION,
  output logic [WADDR-1:0]       o_SLV_ADDR,
  output logic                   o_RW,
  output logic [WDATA-1:0]       o_SLV_WDATA,
  output logic [NREQ-1:0]        o_ack,
  output logic [WDATA-1:0]       o_rdata,
  output logic                   o_err
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_grant;
  logic [PW-1:0]   w_winner;
  logic            w_found;
  logic            w_done;
  logic            w_timeout;
  logic            w_finish;
  logic [WADDR-1:0] w_sel_addr;
  logic            w_sel_rw;
  logic [WDATA-1:0] w_sel_wdata;

  function automatic logic [PW-1:0] rotIdx(input logic [PW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // First active request at or after the pointer, wrapping around.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[rotIdx(r_ptr, i)]) begin
        w_winner = rotIdx(r_ptr, i);
        w_found  = 1'b1;
      end
    end
  end

  assign w_sel_addr  = i_req_addr[int'(w_winner)*WADDR +: WADDR];
  assign w_sel_rw    = i_req_rw[w_winner];
  assign w_sel_wdata = i_req_wdata[int'(w_winner)*WDATA +: WDATA];
  assign w_done      = i_PSEL & i_PENABLE & i_PREADY;
  assign w_finish    = w_done | w_timeout;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_tcnt;

  assign w_timeout = (r_state == BUSY) && (r_tcnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      r_tcnt <= '0;
    end else if (r_state == IDLE) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (|i_req) w_next_state = BUSY;
      BUSY:    if (w_finish) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Command capture on grant, completion bookkeeping on finish; o_ack is a one-cycle pulse.
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      o_TRANSACTION <= 1'b0;
      o_SLV_ADDR    <= '0;
      o_RW          <= 1'b0;
      o_SLV_WDATA   <= '0;
      o_ack         <= '0;
      o_rdata       <= '0;
      r_ptr         <= '0;
      r_grant       <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      o_err         <= 1'b0;
`endif
    end else begin
      o_ack <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      o_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            o_SLV_ADDR    <= w_sel_addr;
            o_RW          <= w_sel_rw;
            o_SLV_WDATA   <= w_sel_wdata;
            o_TRANSACTION <= 1'b1;
            r_grant       <= w_winner;
          end
        end
        BUSY: begin
          if (w_finish) begin
            o_TRANSACTION  <= 1'b0;
            o_ack[r_grant] <= 1'b1;
            if (!o_RW && w_done) o_rdata <= i_PRDATA;
            r_ptr <= (r_grant == PW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
            o_err <= ~w_done;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
